// File: rtl/wb_stage.sv
// Registered MEM/WB boundary: stall/flush control, sub-word load extraction, result select, rd write gating.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 10,
  parameter int RA_W = 5
`ifdef WB_RETIRE_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ValidM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic [XLEN-1:0] ImmExtM,
  input  logic [PC_W-1:0] PCPlus4M,
  input  logic [RA_W-1:0] RdM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      LoadTypeM,
  input  logic            StallW,
  input  logic            FlushW,
  output logic [XLEN-1:0] ResultW,
  output logic [RA_W-1:0] RdW,
  output logic            RegWriteW,
  output logic            ValidW
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] RetireCount
`endif
);

  logic            valid_p1;
  logic [XLEN-1:0] alu_p1;
  logic [XLEN-1:0] rdata_p1;
  logic [XLEN-1:0] imm_p1;
  logic [PC_W-1:0] pc4_p1;
  logic [RA_W-1:0] rd_p1;
  logic            regwrite_p1;
  logic [1:0]      src_p1;
  logic [2:0]      ltype_p1;

  // Pulls the addressed byte/half out of the aligned word and extends it.
  function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] word,
                                                   input logic [1:0] off,
                                                   input logic [2:0] ltype);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[16 +: 16] : word[0 +: 16];
    case (ltype)
      3'b000:  extract_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  extract_load = {{(XLEN-16){h[15]}}, h};
      3'b010:  extract_load = word;
      3'b100:  extract_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  extract_load = {{(XLEN-16){1'b0}}, h};
      default: extract_load = '0;
    endcase
  endfunction

  // M -> W boundary: flush only kills validity, stall holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_p1    <= 1'b0;
      alu_p1      <= '0;
      rdata_p1    <= '0;
      imm_p1      <= '0;
      pc4_p1      <= '0;
      rd_p1       <= '0;
      regwrite_p1 <= 1'b0;
      src_p1      <= 2'b00;
      ltype_p1    <= 3'b000;
    end else if (FlushW) begin
      valid_p1 <= 1'b0;
    end else if (!StallW) begin
      valid_p1    <= ValidM;
      alu_p1      <= ALUResultM;
      rdata_p1    <= ReadDataM;
      imm_p1      <= ImmExtM;
      pc4_p1      <= PCPlus4M;
      rd_p1       <= RdM;
      regwrite_p1 <= RegWriteM;
      src_p1      <= ResultSrcM;
      ltype_p1    <= LoadTypeM;
    end
  end

  // W stage outputs, combinational from registered fields only
  always_comb begin
    ResultW = alu_p1;
    case (src_p1)
      2'b00:   ResultW = alu_p1;
      2'b01:   ResultW = extract_load(rdata_p1, alu_p1[1:0], ltype_p1);
      2'b10:   ResultW = {{(XLEN-PC_W){1'b0}}, pc4_p1};
      default: ResultW = imm_p1;
    endcase
  end

  assign RdW       = rd_p1;
  assign ValidW    = valid_p1;
  assign RegWriteW = valid_p1 & regwrite_p1 & (|rd_p1);

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_p1;

  // An instruction leaves W (retires) only when it is neither held nor killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_p1 <= '0;
    else if (valid_p1 && !StallW && !FlushW)
      cnt_p1 <= cnt_p1 + 1'b1;
  end

  assign RetireCount = cnt_p1;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; retire-counter checks compile in with WB_RETIRE_CNT_EN.
module tb_wb_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 10;
  localparam int RA_W = 5;
`ifdef WB_RETIRE_CNT_EN
  localparam int CNT_W = 4;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ValidM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] ReadDataM;
  logic [XLEN-1:0] ImmExtM;
  logic [PC_W-1:0] PCPlus4M;
  logic [RA_W-1:0] RdM;
  logic            RegWriteM;
  logic [1:0]      ResultSrcM;
  logic [2:0]      LoadTypeM;
  logic            StallW;
  logic            FlushW;
  logic [XLEN-1:0] ResultW;
  logic [RA_W-1:0] RdW;
  logic            RegWriteW;
  logic            ValidW;
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] RetireCount;
  logic [CNT_W-1:0] exp_cnt;
  logic             mdl_valid;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_stage #(
    .XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W)
`ifdef WB_RETIRE_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .ImmExtM(ImmExtM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
    .StallW(StallW), .FlushW(FlushW), .ResultW(ResultW), .RdW(RdW),
    .RegWriteW(RegWriteW), .ValidW(ValidW)
`ifdef WB_RETIRE_CNT_EN
    , .RetireCount(RetireCount)
`endif
  );

  task automatic drive(input logic v, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rd_data,
                       input logic [XLEN-1:0] imm, input logic [PC_W-1:0] pc4, input logic [RA_W-1:0] rd,
                       input logic rw, input logic [1:0] src, input logic [2:0] lt);
    ValidM = v; ALUResultM = alu; ReadDataM = rd_data; ImmExtM = imm; PCPlus4M = pc4;
    RdM = rd; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt;
  endtask

  // One rising edge, then sample 1 ns later; the retire model tracks the expected count.
  task automatic step();
`ifdef WB_RETIRE_CNT_EN
    if (mdl_valid && !StallW && !FlushW) exp_cnt = exp_cnt + 1'b1;
    if (FlushW) mdl_valid = 1'b0;
    else if (!StallW) mdl_valid = ValidM;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = '0;
    mdl_valid = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    drive(1'b1, 32'h0000_1234, 32'h0, 32'h0, 10'h0, 5'd3, 1'b1, 2'b00, 3'b010);
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = '0; mdl_valid = 1'b0;
`endif
    #3;
    tests++; if (ValidW !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", ValidW); end
    tests++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL reset_regwrite: got %b expected 0", RegWriteW); end
    tests++; if (RdW !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d expected 0", RdW); end
    tests++; if (ResultW !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", ResultW); end
`ifdef WB_RETIRE_CNT_EN
    tests++; if (RetireCount !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", RetireCount); end
`endif
    @(negedge clk); rst_n = 1'b1;
    step();
    tests++; if (ResultW !== 32'h0000_1234 || RdW !== 5'd3 || ValidW !== 1'b1 || RegWriteW !== 1'b1) begin
      fails++; $display("FAIL first_capture: got res=%h rd=%0d v=%b rw=%b expected 00001234 3 1 1", ResultW, RdW, ValidW, RegWriteW);
    end
    // Asynchronous reset in the middle of a cycle while W holds a live instruction.
    #2; rst_n = 1'b0; #1;
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = '0; mdl_valid = 1'b0;
`endif
    tests++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 5'd0 || ResultW !== 32'h0) begin
      fails++; $display("FAIL async_reset: got v=%b rw=%b rd=%0d res=%h expected all 0", ValidW, RegWriteW, RdW, ResultW);
    end
    drive(1'b1, 32'h0000_0055, 32'h0, 32'h0, 10'h0, 5'd9, 1'b1, 2'b00, 3'b010);
    @(negedge clk); rst_n = 1'b1;
    step();
    tests++; if (ResultW !== 32'h0000_0055 || RdW !== 5'd9 || ValidW !== 1'b1) begin
      fails++; $display("FAIL capture_after_reset: got res=%h rd=%0d v=%b expected 00000055 9 1", ResultW, RdW, ValidW);
    end
  endtask

  task automatic test_loads();
    logic [31:0] addr [10] = '{32'h100, 32'h100, 32'h101, 32'h102, 32'h103, 32'h101,
                               32'h103, 32'h102, 32'h100, 32'h100};
    logic [2:0]  lt   [10] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010,
                               3'b100, 3'b000, 3'b001, 3'b011};
    logic [31:0] exp  [10] = '{32'hFFFF_FF82, 32'h0000_0082, 32'h0000_007F, 32'hFFFF_80F1,
                               32'h0000_80F1, 32'h80F1_7F82, 32'h0000_0080, 32'hFFFF_FFF1,
                               32'h0000_7F82, 32'h0000_0000};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, addr[i], 32'h80F1_7F82, 32'hDEAD_0000, 10'h3FF, 5'd5, 1'b1, 2'b01, lt[i]);
      step();
      tests++; if (ResultW !== exp[i]) begin
        fails++; $display("FAIL load_%0d (type %b addr %h): got %h expected %h", i, lt[i], addr[i], ResultW, exp[i]);
      end
    end
  endtask

  task automatic test_result_mux();
    drive(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 32'h1234_5000, 10'h3FC, 5'd1, 1'b1, 2'b10, 3'b010);
    step();
    tests++; if (ResultW !== 32'h0000_03FC) begin fails++; $display("FAIL mux_pc4: got %h expected 000003fc", ResultW); end
    ResultSrcM = 2'b11;
    step();
    tests++; if (ResultW !== 32'h1234_5000) begin fails++; $display("FAIL mux_imm: got %h expected 12345000", ResultW); end
    ResultSrcM = 2'b00;
    step();
    tests++; if (ResultW !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mux_alu: got %h expected deadbeef", ResultW); end
  endtask

  task automatic test_x0_gating();
    drive(1'b1, 32'h0, 32'h0, 32'h0000_0ABC, 10'h0, 5'd0, 1'b1, 2'b11, 3'b010);
    step();
    tests++; if (RegWriteW !== 1'b0 || ResultW !== 32'h0000_0ABC || ValidW !== 1'b1) begin
      fails++; $display("FAIL x0_gate: got rw=%b res=%h v=%b expected 0 00000abc 1", RegWriteW, ResultW, ValidW);
    end
    RdM = 5'd5;
    step();
    tests++; if (RegWriteW !== 1'b1 || RdW !== 5'd5) begin fails++; $display("FAIL rd5_write: got rw=%b rd=%0d expected 1 5", RegWriteW, RdW); end
    ValidM = 1'b0;
    step();
    tests++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL invalid_write: got rw=%b expected 0", RegWriteW); end
    ValidM = 1'b1; RegWriteM = 1'b0;
    step();
    tests++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL no_regwrite: got rw=%b expected 0", RegWriteW); end
  endtask

  task automatic test_stall_flush();
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] held;
`endif
    drive(1'b1, 32'h0, 32'h0, 32'h0000_0111, 10'h0, 5'd7, 1'b1, 2'b11, 3'b010);
    step();
`ifdef WB_RETIRE_CNT_EN
    held = exp_cnt;
`endif
    StallW = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 32'h0000_0222, 10'h0, 5'd9, 1'b1, 2'b11, 3'b010);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (ResultW !== 32'h0000_0111 || RdW !== 5'd7 || ValidW !== 1'b1 || RegWriteW !== 1'b1) begin
        fails++; $display("FAIL stall_hold_%0d: got res=%h rd=%0d v=%b rw=%b expected 00000111 7 1 1", i, ResultW, RdW, ValidW, RegWriteW);
      end
`ifdef WB_RETIRE_CNT_EN
      tests++; if (RetireCount !== held) begin fails++; $display("FAIL stall_count_%0d: got %0d expected %0d", i, RetireCount, held); end
`endif
    end
    FlushW = 1'b1;
    step();
    tests++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 5'd7) begin
      fails++; $display("FAIL stall_flush: got v=%b rw=%b rd=%0d expected 0 0 7", ValidW, RegWriteW, RdW);
    end
    StallW = 1'b0; FlushW = 1'b0;
    step();
`ifdef WB_RETIRE_CNT_EN
    tests++; if (RetireCount !== held) begin fails++; $display("FAIL flush_not_retired: got %0d expected %0d", RetireCount, held); end
`endif
    tests++; if (ResultW !== 32'h0000_0222 || RdW !== 5'd9 || ValidW !== 1'b1) begin
      fails++; $display("FAIL resume_capture: got res=%h rd=%0d v=%b expected 00000222 9 1", ResultW, RdW, ValidW);
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_counter_wrap();
    logic [CNT_W-1:0] want;
    StallW = 1'b0; FlushW = 1'b0;
    ValidM = 1'b0;
    do_reset();
    #1;
    tests++; if (RetireCount !== '0) begin fails++; $display("FAIL wrap_start: got %0d expected 0", RetireCount); end
    // Edge 1 captures instruction 1; edge k+1 retires instruction k.
    for (int k = 1; k <= 18; k++) begin
      drive((k <= 17) ? 1'b1 : 1'b0, k, 32'h0, 32'h0, 10'h0, 5'd4, 1'b1, 2'b00, 3'b010);
      step();
      want = CNT_W'((k - 1) % 16);
      tests++; if (RetireCount !== want) begin fails++; $display("FAIL wrap_edge_%0d: got %0d expected %0d", k, RetireCount, want); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_result_mux();
    test_x0_gating();
    test_stall_flush();
`ifdef WB_RETIRE_CNT_EN
    test_counter_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back stage for the pipelined RISC-V core. It replaces the purely combinational result selector with a registered MEM/WB boundary, stall and flush control, and sub-word load extraction with sign or zero extension. It also gates the register-file write enable and, optionally, counts retired instructions. It sits between the data-memory stage and the register-file write port and the forwarding unit.

## Interface
Parameters:
- XLEN, 32, datapath width (result, ALU, memory word).
- PC_W, 10, width of PC+4 value; zero-extended to XLEN.
- RA_W, 5, register address width.
- CNT_W, 32, retire counter width (only used with WB_RETIRE_CNT_EN).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidM  in  1  MEM-stage instruction valid.
- ALUResultM  in  XLEN  ALU result / load effective address.
- ReadDataM  in  XLEN  raw aligned memory word.
- ImmExtM  in  XLEN  extended immediate (LUI).
- PCPlus4M  in  PC_W  PC+4 (JAL/JALR link).
- RdM  in  RA_W  destination register.
- RegWriteM  in  1  instruction writes rd.
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate.
- LoadTypeM  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- StallW  in  1  hold W register.
- FlushW  in  1  kill the incoming instruction.
- ResultW  out  XLEN  write-back value.
- RdW  out  RA_W  write-back register address.
- RegWriteW  out  1  qualified register-file write enable.
- ValidW  out  1  W stage holds a live instruction.
- RetireCount  out  CNT_W  retired-instruction count (WB_RETIRE_CNT_EN only).

## Operation
- The W register captures all M inputs.
- Update priority per rising edge:
  - FlushW=1: ValidW←0, other fields unchanged.
  - Else StallW=1: hold all fields.
  - Else: capture all fields, ValidW←ValidM.
- Result selection is combinational from the registered fields:
  - 00 → ALUResult.
  - 01 → extracted load value.
  - 10 → {zeros, PCPlus4}.
  - 11 → ImmExt.
- Load extraction uses off = registered ALUResult[1:0]:
  - LB/LBU: byte at ReadData[8*off+7:8*off], sign- or zero-extended to XLEN.
  - LH/LHU: half selected by off[1] (off[0] ignored), sign- or zero-extended.
  - LW: full word; off ignored.
  - Any other LoadType: 0.
- RegWriteW = ValidW & RegWrite & (Rd ≠ 0). ResultW and RdW are driven regardless of RegWriteW.
- A stalled instruction keeps RegWriteW asserted each stalled cycle. Rewriting the same value is harmless.

## Timing
- Latency: one cycle from M inputs to W outputs. No combinational path from M inputs or StallW/FlushW to any output.
- Reset (asynchronous, any time, including mid-stall) clears all registered fields to 0:
  - ValidW=0, RegWriteW=0, RdW=0, ResultW=0 (ResultSrc=00, ALUResult=0).
  - RetireCount=0.
- The first capture occurs on the first rising edge with rst_n=1.
- FlushW and StallW together: flush wins; ValidW←0.
- An instruction retires in any cycle where ValidW=1 and StallW=0 and FlushW=0.
- A valid instruction discarded by a flush while stalled is not retired.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - CNT_W-bit RetireCount register increments by 1 on each retirement (rule in Timing).
  - Wraps from all-ones to 0.
  - Reset to 0.
- Not defined:
  - RetireCount port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset mid-stream: assert rst_n=0 asynchronously while ValidW=1 → all outputs 0 immediately; first edge after release captures the M inputs.
- Byte and half loads: ReadDataM=0x80F1_7F82, ResultSrcM=01.
  - LB off=0 → 0xFFFF_FF82.
  - LBU off=0 → 0x0000_0082.
  - LB off=1 → 0x0000_007F.
  - LH off=2 → 0xFFFF_80F1.
  - LHU off=3 → 0x0000_80F1.
  - LW → 0x80F1_7F82.
- Result mux:
  - ResultSrcM=10, PCPlus4M=0x3FC → ResultW=0x0000_03FC.
  - ResultSrcM=11, ImmExtM=0x12345000 → ResultW=0x12345000.
- x0 gating: RdM=0, RegWriteM=1, ValidM=1 → RegWriteW=0 with ResultW still driven. RdM=5 → RegWriteW=1.
- Stall/flush:
  - StallW=1 for 3 cycles → outputs held and RetireCount unchanged.
  - Then StallW=1 and FlushW=1 in the same cycle → ValidW=0 and RegWriteW=0 next cycle; count unchanged.
- Counter wrap (WB_RETIRE_CNT_EN, CNT_W=4): 17 back-to-back valid unstalled instructions → RetireCount sequence reaches 15, then 0, ending at 1 after the 17th retirement.
